// File: rtl/rotate_capture.sv
// Reassembles the word held in a right-rotating register from its bit-0 tap and
// presents it on a valid/ready output with overrun flag. ROTCAP_PARITY_EN adds a parity port.
module rotate_capture #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rotate,
  input  logic             serial_in,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt
`ifdef ROTCAP_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // sreg keeps only the upper WIDTH-1 bits: its lowest bit is always shifted out unused
  state_t             state_q, state_d;
  logic [WIDTH-2:0]   sreg_q, sreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   word;
  logic [WIDTH-1:0]   data_d;
  logic               valid_d;
  logic               overrun_d;
  logic [CNT_W-1:0]   frame_cnt_d;
  logic               complete;
  logic               deliver;
  logic               drop;
`ifdef ROTCAP_PARITY_EN
  logic               parity_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
`ifdef ROTCAP_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      data_out  <= data_d;
      valid     <= valid_d;
      overrun   <= overrun_d;
      frame_cnt <= frame_cnt_d;
`ifdef ROTCAP_PARITY_EN
      parity    <= parity_d;
`endif
    end
  end

  // Next-state, frame assembly and delivery
  always_comb begin
    word     = {serial_in, sreg_q};
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        if (rotate) begin
          sreg_d  = word[WIDTH-1:1];
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!rotate) begin
          // register reloads when not rotating, so the partial frame is meaningless
          sreg_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          complete = 1'b1;
          sreg_d   = word[WIDTH-1:1];
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          sreg_d = word[WIDTH-1:1];
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    deliver = complete && (!valid || ready);
    drop    = complete && valid && !ready;

    data_d      = data_out;
    valid_d     = valid;
    frame_cnt_d = frame_cnt;
    overrun_d   = overrun;

    if (deliver) begin
      data_d      = word;
      valid_d     = 1'b1;
      frame_cnt_d = frame_cnt + CNT_W'(1);
    end else if (valid && ready) begin
      valid_d = 1'b0;
    end

    // a new drop outranks a same-cycle clear
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end

`ifdef ROTCAP_PARITY_EN
    parity_d = ^data_d;
`endif
  end

endmodule

// File: tb/tb_rotate_capture.sv
// Directed bench for rotate_capture: a 4-bit rotating-register model drives two
// instances (CNT_W=8 and CNT_W=2); expected values are hand-computed.
module tb_rotate_capture;

  logic       clk;
  logic       reset;
  logic       rotate;
  logic       ready;
  logic       clr_ovr;
  logic [3:0] load_val;
  logic [3:0] reg_q;
  logic       serial_in;

  logic [3:0] data8, data2;
  logic       valid8, valid2;
  logic       ovr8, ovr2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
`ifdef ROTCAP_PARITY_EN
  logic       par8, par2;
`endif

  int errors = 0;
  int checks = 0;

  rotate_capture #(.WIDTH(4), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .rotate(rotate), .serial_in(serial_in),
    .ready(ready), .clr_ovr(clr_ovr), .data_out(data8), .valid(valid8),
    .overrun(ovr8), .frame_cnt(cnt8)
`ifdef ROTCAP_PARITY_EN
    , .parity(par8)
`endif
  );

  rotate_capture #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .rotate(rotate), .serial_in(serial_in),
    .ready(ready), .clr_ovr(clr_ovr), .data_out(data2), .valid(valid2),
    .overrun(ovr2), .frame_cnt(cnt2)
`ifdef ROTCAP_PARITY_EN
    , .parity(par2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rotating register model: right-rotate on rotate=1, parallel load otherwise
  always @(posedge clk or negedge reset) begin
    if (!reset) reg_q <= 4'b0000;
    else if (rotate) reg_q <= {reg_q[0], reg_q[3:1]};
    else reg_q <= load_val;
  end
  assign serial_in = reg_q[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rot, input logic [3:0] ld);
    rotate   = rot;
    load_val = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] d, input logic v,
                           input logic o, input logic [7:0] c8, input logic [1:0] c2);
    check({tag, ".data8"}, 32'(data8), 32'(d));
    check({tag, ".data2"}, 32'(data2), 32'(d));
    check({tag, ".valid8"}, 32'(valid8), 32'(v));
    check({tag, ".valid2"}, 32'(valid2), 32'(v));
    check({tag, ".ovr8"}, 32'(ovr8), 32'(o));
    check({tag, ".ovr2"}, 32'(ovr2), 32'(o));
    check({tag, ".cnt8"}, 32'(cnt8), 32'(c8));
    check({tag, ".cnt2"}, 32'(cnt2), 32'(c2));
  endtask

  task automatic check_par(input string tag, input logic p);
`ifdef ROTCAP_PARITY_EN
    check({tag, ".par8"}, 32'(par8), 32'(p));
    check({tag, ".par2"}, 32'(par2), 32'(p));
`else
    if (p !== p) $display("unused");
`endif
  endtask

  initial begin
    reset    = 1'b0;
    rotate   = 1'b0;
    ready    = 1'b1;
    clr_ovr  = 1'b0;
    load_val = 4'b0000;
    #1;
    check_out("por", 4'b0000, 1'b0, 1'b0, 8'd0, 2'd0);
    check_par("por", 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // basic recovery of 1101
    step(1'b0, 4'b1101);
    repeat (3) step(1'b1, 4'b0000);
    check("basic.latency", 32'(valid8), 32'd0);
    step(1'b1, 4'b0000);
    check_out("basic", 4'b1101, 1'b1, 1'b0, 8'd1, 2'd1);
    check_par("basic", 1'b1);

    // load 1010, rotate twice, reload 0110 (abort), then a full frame
    step(1'b0, 4'b1010);
    check("consume.valid", 32'(valid8), 32'd0);
    check("consume.hold", 32'(data8), 32'hd);
    repeat (2) step(1'b1, 4'b0000);
    step(1'b0, 4'b0110);
    check_out("abort", 4'b1101, 1'b0, 1'b0, 8'd1, 2'd1);
    repeat (2) step(1'b1, 4'b0000);
    check("abort.no_early2", 32'(valid8), 32'd0);
    step(1'b1, 4'b0000);
    check("abort.no_early3", 32'(valid8), 32'd0);
    step(1'b1, 4'b0000);
    check_out("abort.frame", 4'b0110, 1'b1, 1'b0, 8'd2, 2'd2);
    check_par("abort.frame", 1'b0);

    // backpressure: 1101 held, 0011 dropped
    step(1'b0, 4'b1101);
    ready = 1'b0;
    repeat (4) step(1'b1, 4'b0000);
    check_out("bp.first", 4'b1101, 1'b1, 1'b0, 8'd3, 2'd3);
    step(1'b0, 4'b0011);
    check("bp.stable", 32'(valid8), 32'd1);
    repeat (4) step(1'b1, 4'b0000);
    check_out("bp.drop", 4'b1101, 1'b1, 1'b1, 8'd3, 2'd3);

    // clr_ovr on a dropping edge: set wins
    step(1'b0, 4'b0011);
    repeat (3) step(1'b1, 4'b0000);
    clr_ovr = 1'b1;
    step(1'b1, 4'b0000);
    clr_ovr = 1'b0;
    check_out("clr_vs_set", 4'b1101, 1'b1, 1'b1, 8'd3, 2'd3);

    ready = 1'b1;
    step(1'b0, 4'b0000);
    check_out("bp.release", 4'b1101, 1'b0, 1'b1, 8'd3, 2'd3);
    clr_ovr = 1'b1;
    step(1'b0, 4'b0000);
    clr_ovr = 1'b0;
    check_out("bp.clr", 4'b1101, 1'b0, 1'b0, 8'd3, 2'd3);

    // 1001 delivered, then 0110 completes with valid=1 and ready=1
    step(1'b0, 4'b1001);
    repeat (4) step(1'b1, 4'b0000);
    check_out("simul.a", 4'b1001, 1'b1, 1'b0, 8'd4, 2'd0);
    ready = 1'b0;
    step(1'b0, 4'b0110);
    repeat (3) step(1'b1, 4'b0000);
    ready = 1'b1;
    step(1'b1, 4'b0000);
    check_out("simul.b", 4'b0110, 1'b1, 1'b0, 8'd5, 2'd1);

    // next frame follows with no gap
    step(1'b1, 4'b0000);
    check("gap.consume", 32'(valid8), 32'd0);
    repeat (3) step(1'b1, 4'b0000);
    check_out("gap.c", 4'b0110, 1'b1, 1'b0, 8'd6, 2'd2);

    // dropped frame sets overrun, then reset mid-frame
    ready = 1'b0;
    step(1'b0, 4'b1111);
    repeat (4) step(1'b1, 4'b0000);
    check_out("pre_rst", 4'b0110, 1'b1, 1'b1, 8'd6, 2'd2);
    step(1'b0, 4'b1011);
    repeat (2) step(1'b1, 4'b0000);
    reset = 1'b0;
    #2;
    check_out("async_rst", 4'b0000, 1'b0, 1'b0, 8'd0, 2'd0);
    check_par("async_rst", 1'b0);
    ready   = 1'b1;
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    check_out("in_rst", 4'b0000, 1'b0, 1'b0, 8'd0, 2'd0);
    clr_ovr = 1'b0;
    reset   = 1'b1;

    // first frame after release
    step(1'b0, 4'b1011);
    repeat (4) step(1'b1, 4'b0000);
    check_out("post_rst", 4'b1011, 1'b1, 1'b0, 8'd1, 2'd1);
    check_par("post_rst", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
